monolith_host_driver: RTL and testbench
=======================================

# monolith_host_driver

Host-side sequencer that drives the Monolith hash engine's go/valid pin protocol on behalf of a ready/valid request stream. It accepts one hash or compress request at a time and canonicalises the Mersenne-31 operands. It presents the operands to the engine, holds `go` for the whole computation and captures the 31-bit result. The result returns on a tagged ready/valid response port, with a timeout error path. It sits between the system interconnect and the Monolith top-level, one instance per engine.

## Interface
- `TAG_W`, 4: width of the request/response tag.
- `TIMEOUT_CYCLES`, 64: `RUN` cycles allowed before a job is aborted. Legal range 2..65535.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: driver can accept a request.
- `req_in1` in 31: first operand.
- `req_in2` in 31: second operand, used only when `req_mode`=1.
- `req_mode` in 1: 0 = hash, 1 = compress.
- `req_tag` in TAG_W: opaque tag, returned with the response.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 31: hash/compress result.
- `resp_tag` out TAG_W: tag of the completed request.
- `resp_err` out 1: 1 = the engine timed out; `resp_data` is then 0.
- `eng_in1` out 31: to the engine's `in1`.
- `eng_in2` out 31: to the engine's `in2`.
- `eng_hash_or_compress` out 1: to the engine's mode input.
- `eng_go` out 1: to the engine's `go`.
- `eng_out` in 31: the engine's result.
- `eng_valid` in 1: the engine's result-valid flag.

## Operation
- **FSM states:** `IDLE`, `LOAD`, `RUN`, `DONE`.
- **`IDLE`:**
  - `req_ready`=1.
  - A handshake (`req_valid`&&`req_ready`) latches the operands, mode and tag, then moves to `LOAD`.
- **Canonicalisation:**
  - An operand equal to 31'h7FFF_FFFF (p) is latched as 0. All other values pass unchanged.
  - When `req_mode`=0, the latched `in2` is forced to 0.
- **`eng_*` outputs:**
  - `eng_in1`, `eng_in2` and `eng_hash_or_compress` are registered.
  - They hold the latched values from `LOAD` through `DONE`, and change only on a new accept.
- **`LOAD`:** lasts exactly 1 cycle with `eng_go`=0, so the engine's input registers capture the operands before `go` rises. Then moves to `RUN`.
- **`RUN`:**
  - `eng_go`=1.
  - A cycle counter starts at 0 on entry and increments each `RUN` cycle.
  - `eng_valid` is ignored while the counter is 0 (stale-valid guard).
  - When `eng_valid`=1 with counter ≥1: capture `eng_out` into `resp_data`, set `resp_err`=0, go to `DONE`.
  - When the counter reaches `TIMEOUT_CYCLES`-1 without a valid: set `resp_data`=0 and `resp_err`=1, go to `DONE`.
  - If a valid and the timeout occur in the same cycle, the valid wins.
- **`DONE`:**
  - `eng_go`=0, which hard-resets the engine.
  - `resp_valid`=1. `resp_data`, `resp_tag` and `resp_err` are stable until the response handshake.
  - On `resp_ready`=1, go to `IDLE`.
- **Back-to-back jobs:** because `DONE` lasts at least 1 cycle and `LOAD` is 1 cycle, `eng_go` is low for at least 2 cycles between jobs.
- **Backpressure:** `req_ready`=0 in every state except `IDLE`, so there is no overlap of jobs.
- **Reset values:**
  - State `IDLE`.
  - `req_ready`=1.
  - `resp_valid`=0, `resp_data`=0, `resp_tag`=0, `resp_err`=0.
  - `eng_in1`=0, `eng_in2`=0, `eng_hash_or_compress`=0, `eng_go`=0.
  - Counter=0.
- **Reset mid-operation:** any state returns to `IDLE` at the next edge. `eng_go` drops at that edge and the in-flight job is discarded with no response.

## Timing
- Cycle t: request handshake.
- Cycle t+1: `LOAD`; `eng_*` operands are valid.
- Cycles t+2 onward: `RUN` with `eng_go`=1.
- If the engine raises `eng_valid` in `RUN` cycle k (k≥1, counter value), `resp_valid` rises at cycle t+3+k.
- Total latency from accept to `resp_valid` is engine latency + 3 cycles.
- A response held under backpressure keeps `eng_go`=0 for its whole duration.
- Earliest next accept is the cycle after the response handshake, when `req_ready` has returned to 1.
- Timeout response: `resp_valid` rises at t+2+`TIMEOUT_CYCLES`.
- Throughput: 1 job per (engine latency + 4) cycles when `resp_ready` is tied high.

## Test plan
- **Hash request:** mock engine with 12-cycle latency returning `in1`^5A5A5A5A; request hash with `in1`=123, `in2`=999, tag 3.
  - `eng_in2`=0.
  - `eng_go` rises 2 cycles after accept.
  - `resp_data`=123^5A5A5A5A, `resp_tag`=3, `resp_err`=0.
  - Accept-to-`resp_valid` latency = 15 cycles.
- **Compress with canonicalisation:** request compress with `in1`=7FFFFFFF, `in2`=5.
  - `eng_in1`=0, `eng_in2`=5, `eng_hash_or_compress`=1 throughout `LOAD`..`DONE`.
- **Timeout:** `TIMEOUT_CYCLES`=8, engine never asserts `eng_valid`.
  - `resp_valid` rises 10 cycles after accept with `resp_err`=1 and `resp_data`=0.
  - `eng_go` falls in `DONE`.
- **Stale valid:** `eng_valid` is held at 1 on the first `RUN` cycle, then 0, then 1 at k=4.
  - Response is captured at k=4 only.
- **Backpressure and back-to-back jobs:** two queued requests with `resp_ready` low for 5 cycles.
  - `resp_*` are stable during the stall and `req_ready`=0.
  - The second job is accepted only after the first response handshake.
  - `eng_go` is low for ≥2 cycles between jobs.
- **Reset mid-`RUN`:** pulse `reset` during `RUN`.
  - Next cycle: `eng_go`=0, `resp_valid`=0, `req_ready`=1.
  - No response is emitted for the aborted tag.

Source files
------------

// File: rtl/monolith_host_driver.sv
// Host-side sequencer for the Monolith hash engine: accepts one tagged request at a time,
// drives the engine's go/valid protocol and returns the result or a timeout error.
module monolith_host_driver #(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [30:0]      req_in1,
  input  logic [30:0]      req_in2,
  input  logic             req_mode,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [30:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic [30:0]      eng_in1,
  output logic [30:0]      eng_in2,
  output logic             eng_hash_or_compress,
  output logic             eng_go,
  input  logic [30:0]      eng_out,
  input  logic             eng_valid
);

  localparam logic [30:0] ModP    = 31'h7FFF_FFFF;
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [30:0]        in1_q, in1_d;
  logic [30:0]        in2_q, in2_d;
  logic               mode_q, mode_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [30:0]        data_q, data_d;
  logic               err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          // p is congruent to 0; hash mode never uses the second operand.
          in1_d   = (req_in1 == ModP) ? 31'd0 : req_in1;
          in2_d   = (req_mode && (req_in2 != ModP)) ? req_in2 : 31'd0;
          mode_d  = req_mode;
          tag_d   = req_tag;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = 16'd0;
        state_d = StRun;
      end
      StRun: begin
        // A valid on the first go cycle is left over from the previous job.
        if (eng_valid && (cnt_q != 16'd0)) begin
          data_d  = eng_out;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          data_d  = 31'd0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      in1_q   <= 31'd0;
      in2_q   <= 31'd0;
      mode_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= 31'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready            = (state_q == StIdle);
  assign resp_valid           = (state_q == StDone);
  assign resp_data            = data_q;
  assign resp_tag             = tag_q;
  assign resp_err             = err_q;
  assign eng_in1              = in1_q;
  assign eng_in2              = in2_q;
  assign eng_hash_or_compress = mode_q;
  assign eng_go               = (state_q == StRun);

endmodule

// File: tb/tb_monolith_host_driver.sv
// Scoreboard bench for monolith_host_driver: directed requests against a mock engine, plus a
// second instance with a short timeout and a silent engine.
module tb_monolith_host_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [30:0] data;
    logic [3:0]  tag;
    logic        err;
    int          lat;
    int          t;
    logic [30:0] e1;
    logic [30:0] e2;
    logic        em;
  } exp_t;

  // ---------------- instance A: default timeout, programmable mock engine
  logic        req_valid = 1'b0, req_mode = 1'b0, resp_ready = 1'b1;
  logic [30:0] req_in1 = '0, req_in2 = '0;
  logic [3:0]  req_tag = '0;
  logic        req_ready, resp_valid, resp_err, eng_hoc, eng_go, eng_valid;
  logic [30:0] resp_data, eng_in1, eng_in2, eng_out;
  logic [3:0]  resp_tag;

  monolith_host_driver dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_in1(req_in1), .req_in2(req_in2),
    .req_mode(req_mode), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .eng_in1(eng_in1), .eng_in2(eng_in2), .eng_hash_or_compress(eng_hoc), .eng_go(eng_go),
    .eng_out(eng_out), .eng_valid(eng_valid)
  );

  // Mock engine: counts go cycles; mode 0 = 12-cycle latency, mode 1 = stale valid at 0 and 4.
  int          emode = 0;
  int          mcnt = 0;
  logic [30:0] mres;
  always @(posedge clk) mcnt <= eng_go ? mcnt + 1 : 0;
  always_comb begin
    mres = eng_hoc ? (eng_in1 ^ eng_in2 ^ 31'h5A5A5A5A) : (eng_in1 ^ 31'h5A5A5A5A);
    if (emode == 1) begin
      eng_valid = eng_go && ((mcnt == 0) || (mcnt == 4));
      eng_out   = (mcnt == 0) ? 31'h1111 : mres;
    end else begin
      eng_valid = eng_go && (mcnt == 12);
      eng_out   = mres;
    end
  end

  exp_t q[$];
  logic rv_prev = 1'b0, go_prev = 1'b0, had_go = 1'b0;
  int   go_low = 0;

  always @(negedge clk) begin
    if (reset) begin
      rv_prev = 1'b0;
    end else begin
      if (!req_ready && q.size() > 0) begin
        chk("eng_in1", eng_in1, q[0].e1);
        chk("eng_in2", eng_in2, q[0].e2);
        chk("eng_mode", eng_hoc, q[0].em);
      end
      if (eng_go && !go_prev) begin
        if (q.size() > 0) chk("go_rise_delay", cyc - q[0].t, 2);
        if (had_go) chk("go_gap_ge2", go_low >= 2, 1);
        had_go = 1'b1;
      end
      go_low  = eng_go ? 0 : go_low + 1;
      go_prev = eng_go;
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", resp_tag, 4'hF);
        end else begin
          if (!rv_prev) chk("latency", cyc - q[0].t, q[0].lat);
          chk("resp_data", resp_data, q[0].data);
          chk("resp_tag", resp_tag, q[0].tag);
          chk("resp_err", resp_err, q[0].err);
          chk("go_low_in_done", eng_go, 0);
          chk("req_ready_in_done", req_ready, 0);
          if (resp_ready) void'(q.pop_front());
        end
      end
      rv_prev = resp_valid && !resp_ready;
    end
  end

  task automatic send(input logic [30:0] i1, input logic [30:0] i2, input logic m,
                      input logic [3:0] tg, input logic [30:0] ed, input logic [30:0] e1,
                      input logic [30:0] e2, input int lat);
    exp_t e;
    int   w;
    @(negedge clk);
    req_valid = 1'b1; req_in1 = i1; req_in2 = i2; req_mode = m; req_tag = tg;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      chk("prev_resp_done_at_accept", q.size(), 0);
      e.data = ed; e.tag = tg; e.err = 1'b0; e.lat = lat; e.t = cyc;
      e.e1 = e1; e.e2 = e2; e.em = m;
      q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain;
    int w = 0;
    while (q.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // ---------------- instance B: TIMEOUT_CYCLES=8, engine never answers
  logic        b_req_valid = 1'b0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_hoc, b_go;
  logic [30:0] b_resp_data, b_in1, b_in2;
  logic [3:0]  b_resp_tag;

  monolith_host_driver #(.TAG_W(4), .TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_in1(31'd42), .req_in2(31'd0),
    .req_mode(1'b0), .req_tag(4'd6),
    .resp_valid(b_resp_valid), .resp_ready(1'b1), .resp_data(b_resp_data),
    .resp_tag(b_resp_tag), .resp_err(b_resp_err),
    .eng_in1(b_in1), .eng_in2(b_in2), .eng_hash_or_compress(b_hoc), .eng_go(b_go),
    .eng_out(31'h1234), .eng_valid(1'b0)
  );

  exp_t qb[$];
  always @(negedge clk) begin
    if (!reset && b_resp_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_resp", b_resp_tag, 4'hF);
      end else begin
        chk("b_latency", cyc - qb[0].t, qb[0].lat);
        chk("b_resp_data", b_resp_data, qb[0].data);
        chk("b_resp_err", b_resp_err, qb[0].err);
        chk("b_resp_tag", b_resp_tag, qb[0].tag);
        chk("b_go_low_in_done", b_go, 0);
        void'(qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t eb;
    int   w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_eng_in1", eng_in1, 0);
    chk("rst_eng_in2", eng_in2, 0);
    chk("rst_eng_mode", eng_hoc, 0);
    chk("rst_eng_go", eng_go, 0);

    // Hash: in2 dropped, 123 ^ 5A5A5A5A, 12-cycle engine -> 15-cycle latency.
    send(31'd123, 31'd999, 1'b0, 4'd3, 31'h5A5A5A21, 31'd123, 31'd0, 15);
    drain();
    // Compress with p canonicalised to 0: 0 ^ 5 ^ 5A5A5A5A.
    send(31'h7FFFFFFF, 31'd5, 1'b1, 4'd5, 31'h5A5A5A5F, 31'd0, 31'd5, 15);
    drain();
    // Stale valid on first go cycle must be ignored; capture at k=4.
    emode = 1;
    send(31'h10, 31'd0, 1'b0, 4'd7, 31'h5A5A5A4A, 31'h10, 31'd0, 7);
    drain();
    emode = 0;

    // Backpressure: two jobs queued, first response stalled 5 cycles.
    resp_ready = 1'b0;
    fork
      begin
        send(31'd1, 31'h7FFFFFFF, 1'b1, 4'd9, 31'h5A5A5A5B, 31'd1, 31'd0, 15);
        send(31'h7FFFFFFE, 31'd3, 1'b0, 4'd10, 31'h25A5A5A4, 31'h7FFFFFFE, 31'd0, 15);
      end
      begin
        w = 0;
        while (!resp_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        chk("bp_resp_seen", resp_valid, 1);
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
      end
    join
    drain();

    // Reset during RUN discards the job.
    send(31'd2, 31'd0, 1'b0, 4'd12, 31'h5A5A5A58, 31'd2, 31'd0, 15);
    repeat (5) @(posedge clk);
    chk("run_before_reset", eng_go, 1);
    #1 reset = 1'b1;
    @(posedge clk);
    q.delete();
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_eng_go", eng_go, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    send(31'd3, 31'd0, 1'b0, 4'd13, 31'h5A5A5A59, 31'd3, 31'd0, 15);
    drain();

    // Timeout with TIMEOUT_CYCLES=8: response 10 cycles after accept.
    @(negedge clk);
    chk("b_req_ready_idle", b_req_ready, 1);
    b_req_valid = 1'b1;
    eb.data = 31'd0; eb.tag = 4'd6; eb.err = 1'b1; eb.lat = 10; eb.t = cyc;
    eb.e1 = 31'd42; eb.e2 = 31'd0; eb.em = 1'b0;
    qb.push_back(eb);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    w = 0;
    while (qb.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("b_timeout_resp_seen", qb.size(), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
